alu_request_arbiter: RTL

Round-robin arbiter and sequencer that shares one 32-bit ALU/result-mux datapath (4-bit select, two 32-bit operands) among NREQ requesters.
- Accepts one request at a time and latches its select and operands onto the datapath.
- Holds them stable for a fixed settle window, since the gate-level datapath needs many cycles to propagate.
- Captures the result and returns it to the winning requester over a valid/ready handshake.
- Sits between the requesting units and the ALU top; it is the only driver of the datapath select/operand inputs.

---
 rtl/alu_request_arbiter_pkg.sv | 26 ++
 rtl/alu_request_arbiter_rr_priority_picker.sv | 42 ++++
 rtl/alu_request_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_request_arbiter_pkg
//  Description : Shared constants and state encoding for the ALU request
//                arbiter and its round-robin picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_request_arbiter_pkg;

   // Datapath geometry defaults
   localparam int C_WORD_DEF  = 32;
   localparam int C_SEL_W_DEF = 4;

   // Datapath select codes used by the pass-through result mux
   localparam logic [C_SEL_W_DEF-1:0] C_SEL_PASS_A = 4'd0;
   localparam logic [C_SEL_W_DEF-1:0] C_SEL_PASS_B = 4'd1;

   // Sequencer state encoding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_request_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_picker
//  Description : Combinational round-robin picker. Scans requesters starting
//                one past the last grant, wrapping modulo NREQ, and returns
//                the first valid index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
   import alu_request_arbiter_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_valid,
   input  logic [$clog2(NREQ)-1:0] last_grant,
   output logic                    any_valid,
   output logic [$clog2(NREQ)-1:0] grant
);

   localparam int GW = $clog2(NREQ);

   logic [GW:0] w_idx;

   // Wraparound scan; the first hit after last_grant wins
   always_comb begin
      any_valid = 1'b0;
      grant     = '0;
      w_idx     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = {1'b0, last_grant} + (GW+1)'(k);
         if (w_idx >= (GW+1)'(NREQ)) begin
            w_idx = w_idx - (GW+1)'(NREQ);
         end
         if (!any_valid && req_valid[w_idx[GW-1:0]]) begin
            any_valid = 1'b1;
            grant     = w_idx[GW-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_request_arbiter
//  Description : Round-robin arbiter/sequencer sharing one slow ALU datapath
//                among NREQ requesters. Latches the winner's select and
//                operands, holds them for SETTLE_CYCLES, captures the result
//                and returns it over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_request_arbiter
   import alu_request_arbiter_pkg::*;
#(
   parameter int NREQ          = 4,
   parameter int WORD          = C_WORD_DEF,
   parameter int SEL_W         = C_SEL_W_DEF,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*SEL_W-1:0] req_sel,
   input  logic [NREQ*WORD-1:0]  req_a,
   input  logic [NREQ*WORD-1:0]  req_b,
   output logic [SEL_W-1:0]      alu_sel,
   output logic [WORD-1:0]       alu_a,
   output logic [WORD-1:0]       alu_b,
   input  logic [WORD-1:0]       alu_result,
   output logic [NREQ-1:0]       resp_valid,
   input  logic [NREQ-1:0]       resp_ready,
   output logic [WORD-1:0]       resp_data,
   output logic                  busy
);

   localparam int            GW         = $clog2(NREQ);
   localparam int            CW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] C_CNT_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [GW-1:0] C_LAST_RST = GW'(NREQ - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic [GW-1:0]     r_grant;
   logic [GW-1:0]     r_last_grant;
   logic [GW-1:0]     w_pick;
   logic              w_any;
   logic              w_accept;
   logic              w_capture;
   logic              w_release;
   logic [NREQ-1:0]   w_ready_raw;
   logic [SEL_W-1:0]  r_alu_sel;
   logic [WORD-1:0]   r_alu_a;
   logic [WORD-1:0]   r_alu_b;
   logic [NREQ-1:0]   r_resp_valid;
   logic [WORD-1:0]   r_resp_data;

   rr_priority_picker #(
      .NREQ (NREQ)
   ) u_picker (
      .req_valid  (req_valid),
      .last_grant (r_last_grant),
      .any_valid  (w_any),
      .grant      (w_pick)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and the accept/capture/release strobes
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_release   = 1'b0;
      w_ready_raw = '0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_accept            = 1'b1;
               w_ready_raw[w_pick] = 1'b1;
               w_state_nxt         = SETTLE;
            end
         end
         SETTLE: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            if (resp_ready[r_grant]) begin
               w_release   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Operand latch, settle counter, result capture and grant bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_grant      <= '0;
         r_last_grant <= C_LAST_RST;
         r_alu_sel    <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_resp_valid <= '0;
         r_resp_data  <= '0;
      end else begin
         if (w_accept) begin
            r_alu_sel <= req_sel[w_pick*SEL_W +: SEL_W];
            r_alu_a   <= req_a[w_pick*WORD +: WORD];
            r_alu_b   <= req_b[w_pick*WORD +: WORD];
            r_cnt     <= C_CNT_LOAD;
            r_grant   <= w_pick;
         end else if ((r_state == SETTLE) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_capture) begin
            r_resp_data  <= alu_result;
            r_resp_valid <= NREQ'(1) << r_grant;
         end
         if (w_release) begin
            r_resp_valid <= '0;
            r_last_grant <= r_grant;
         end
      end
   end

   // Ready is forced low while reset is held so every output reads zero
   assign req_ready  = w_ready_raw & {NREQ{rst_n}};
   assign alu_sel    = r_alu_sel;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire
